// File: rtl/flash_pkg.sv
// Shared types and constants for the flash sample reader and its Avalon read handshake.
package flash_pkg;

    localparam int unsigned FLASH_ADDR_W  = 23;
    localparam int unsigned FLASH_DATA_W  = 32;
    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned FLASH_BURST_W = 7;
    localparam int unsigned FLASH_BE_W    = 4;

    localparam logic [FLASH_BURST_W-1:0] FLASH_BURSTCOUNT = 7'd1;
    localparam logic [FLASH_BE_W-1:0]    FLASH_BYTEENABLE = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitData,
        StOutLo,
        StOutHi,
        StFinish
    } reader_state_e;

    typedef enum logic [1:0] {
        ReqIdle,
        ReqIssue,
        ReqWait
    } req_state_e;

endpackage

// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read/write bus towards the flash core; the reader uses the master modport.
interface flash_sample_reader_if;
    import flash_pkg::*;

    logic                     read;
    logic [FLASH_ADDR_W-1:0]  address;
    logic [FLASH_BURST_W-1:0] burstcount;
    logic                     write;
    logic [FLASH_BE_W-1:0]    byteenable;
    logic [FLASH_DATA_W-1:0]  writedata;
    logic                     waitrequest;
    logic [FLASH_DATA_W-1:0]  readdata;
    logic                     readdatavalid;

    modport master (
        output read, address, burstcount, write, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, address, burstcount, write, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/flash_req_ctrl.sv
// Single-outstanding Avalon read: latches the address on go, holds read until accepted,
// then waits for readdatavalid and returns the word with a one-cycle word_valid.
module flash_req_ctrl
    import flash_pkg::*;
(
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    go,
    input  logic [FLASH_ADDR_W-1:0] addr,
    flash_sample_reader_if.master   flash_mem,
    output logic                    accepted,
    output logic [FLASH_DATA_W-1:0] word,
    output logic                    word_valid
);

    req_state_e              state_q, state_d;
    logic [FLASH_ADDR_W-1:0] address_q, address_d;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= ReqIdle;
            address_q <= '0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        accepted   = 1'b0;
        word_valid = 1'b0;
        unique case (state_q)
            ReqIdle: begin
                if (go) begin
                    address_d = addr;
                    state_d   = ReqIssue;
                end
            end
            ReqIssue: begin
                if (!flash_mem.waitrequest) begin
                    accepted = 1'b1;
                    state_d  = ReqWait;
                end
            end
            ReqWait: begin
                // Responses arriving outside this state are dropped.
                if (flash_mem.readdatavalid) begin
                    word_valid = 1'b1;
                    state_d    = ReqIdle;
                end
            end
            default: state_d = ReqIdle;
        endcase
    end

    assign flash_mem.read       = (state_q == ReqIssue);
    assign flash_mem.address    = address_q;
    assign flash_mem.burstcount = FLASH_BURSTCOUNT;
    assign flash_mem.write      = 1'b0;
    assign flash_mem.byteenable = FLASH_BYTEENABLE;
    assign flash_mem.writedata  = '0;
    assign word                 = flash_mem.readdata;

endmodule

// File: rtl/flash_sample_reader.sv
// Streams flash words in [START_ADDR, END_ADDR] as 16-bit samples, low half first.
// Define FLASH_READER_LOOP_EN to restart at START_ADDR after each pass instead of idling.
module flash_sample_reader
    import flash_pkg::*;
#(
    parameter logic [FLASH_ADDR_W-1:0] START_ADDR = 23'd0,
    parameter logic [FLASH_ADDR_W-1:0] END_ADDR   = 23'h1FFFFF
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  start,
    flash_sample_reader_if.master flash_mem,
    output logic [SAMPLE_W-1:0]   sample,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [FLASH_ADDR_W-1:0] ADDR_ONE = 1;

    reader_state_e           state_q, state_d;
    logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
    logic [FLASH_DATA_W-1:0] word_q, word_d;
    logic                    go, accepted, word_valid;
    logic [FLASH_DATA_W-1:0] word;

    flash_req_ctrl u_req_ctrl (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .go          (go),
        .addr        (addr_d),
        .flash_mem   (flash_mem),
        .accepted    (accepted),
        .word        (word),
        .word_valid  (word_valid)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
        end
    end

    // go launches the next read in the same cycle the FSM enters StReq, so read rises next edge.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_d       = word_q;
        go           = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = START_ADDR;
                    go      = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (accepted) state_d = StWaitData;
            end
            StWaitData: begin
                if (word_valid) begin
                    word_d  = word;
                    state_d = StOutLo;
                end
            end
            StOutLo: begin
                sample       = word_q[SAMPLE_W-1:0];
                sample_valid = 1'b1;
                if (sample_ready) state_d = StOutHi;
            end
            StOutHi: begin
                sample       = word_q[FLASH_DATA_W-1:SAMPLE_W];
                sample_valid = 1'b1;
                if (sample_ready) begin
                    if (addr_q == END_ADDR) begin
                        state_d = StFinish;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        go      = 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StFinish: begin
                done = 1'b1;
`ifdef FLASH_READER_LOOP_EN
                addr_d  = START_ADDR;
                go      = 1'b1;
                state_d = StReq;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench: two readers (window 0..0 and 4..6) on behavioural flash responders.
module tb_flash_sample_reader;
    import flash_pkg::*;

    logic clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    logic        reset_reset, start_a, start_b, ready_a, ready_b;
    logic [15:0] sample_a, sample_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    flash_sample_reader_if bus_a ();
    flash_sample_reader_if bus_b ();

    flash_sample_reader #(.START_ADDR(23'd0), .END_ADDR(23'd0)) dut_a (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .start        (start_a),
        .flash_mem    (bus_a),
        .sample       (sample_a),
        .sample_valid (valid_a),
        .sample_ready (ready_a),
        .busy         (busy_a),
        .done         (done_a)
    );

    flash_sample_reader #(.START_ADDR(23'd4), .END_ADDR(23'd6)) dut_b (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .start        (start_b),
        .flash_mem    (bus_b),
        .sample       (sample_b),
        .sample_valid (valid_b),
        .sample_ready (ready_b),
        .busy         (busy_b),
        .done         (done_b)
    );

    int n_tests, n_fail;
    int stall_a, stall_b;
    logic inject_b;

    // Responder state: each request stalls stall_x cycles, data returns one cycle after accept.
    int          wcnt_a, wcnt_b, acc_cnt_a, done_cnt_b;
    logic        due_a, due_b;
    logic [22:0] pend_b;
    logic [22:0] acc_b[$];
    logic [15:0] smp_b[$];

    function automatic logic [31:0] word_b(input logic [22:0] a);
        return {16'hA000 + a[15:0], 16'h5000 + a[15:0]};
    endfunction

    always @(negedge clk_clk) begin
        bus_a.readdatavalid = 1'b0;
        if (due_a === 1'b1) begin
            bus_a.readdatavalid = 1'b1;
            bus_a.readdata      = 32'hBEEF_1234;
            due_a               = 1'b0;
        end
        bus_a.waitrequest = (bus_a.read === 1'b1) && (wcnt_a < stall_a);
        if (bus_a.waitrequest) wcnt_a++;
        else wcnt_a = 0;
        if (bus_a.read === 1'b1 && !bus_a.waitrequest) begin
            due_a = 1'b1;
            acc_cnt_a++;
        end
    end

    always @(negedge clk_clk) begin
        bus_b.readdatavalid = 1'b0;
        if (due_b === 1'b1) begin
            bus_b.readdatavalid = 1'b1;
            bus_b.readdata      = word_b(pend_b);
            due_b               = 1'b0;
        end else if (inject_b === 1'b1) begin
            bus_b.readdatavalid = 1'b1;
            bus_b.readdata      = 32'hDEAD_BEEF;
        end
        bus_b.waitrequest = (bus_b.read === 1'b1) && (wcnt_b < stall_b);
        if (bus_b.waitrequest) wcnt_b++;
        else wcnt_b = 0;
        if (bus_b.read === 1'b1 && !bus_b.waitrequest) begin
            due_b  = 1'b1;
            pend_b = bus_b.address;
            acc_b.push_back(bus_b.address);
        end
    end

    always @(posedge clk_clk) begin
        if (valid_b === 1'b1 && ready_b === 1'b1) smp_b.push_back(sample_b);
        if (done_b === 1'b1) done_cnt_b++;
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_smp [6];
        logic [22:0] exp_addr [3];
        int          n0, d0;
        exp_smp  = '{16'h5004, 16'hA004, 16'h5005, 16'hA005, 16'h5006, 16'hA006};
        exp_addr = '{23'd4, 23'd5, 23'd6};
        n_tests = 0; n_fail = 0;
        reset_reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        stall_a = 0; stall_b = 0; inject_b = 1'b0;
        repeat (3) tick();
        reset_reset = 1'b0;
        tick();

        check("rst_read",    32'(bus_a.read),    32'd0);
        check("rst_address", 32'(bus_a.address), 32'd0);
        check("rst_sample",  32'(sample_a),      32'd0);
        check("rst_valid",   32'(valid_a),       32'd0);
        check("rst_busy",    32'(busy_a),        32'd0);
        check("rst_done",    32'(done_a),        32'd0);
        check("const_burst", 32'(bus_a.burstcount), 32'd1);
        check("const_be",    32'(bus_a.byteenable), 32'hF);

        // Reset while a read is stalled on waitrequest.
        stall_b = 100;
        start_b = 1'b1; tick(); start_b = 1'b0;
        check("req_read", 32'(bus_b.read),    32'd1);
        check("req_addr", 32'(bus_b.address), 32'd4);
        check("req_busy", 32'(busy_b),        32'd1);
        tick(); tick();
        check("stall_read", 32'(bus_b.read), 32'd1);
        reset_reset = 1'b1; tick(); reset_reset = 1'b0;
        check("midrst_read",   32'(bus_b.read),    32'd0);
        check("midrst_addr",   32'(bus_b.address), 32'd0);
        check("midrst_busy",   32'(busy_b),        32'd0);
        check("midrst_valid",  32'(valid_b),       32'd0);
        check("midrst_sample", 32'(sample_b),      32'd0);
        check("midrst_done",   32'(done_b),        32'd0);
        stall_b = 0; inject_b = 1'b1;
        tick(); inject_b = 1'b0; tick();
        check("stale_valid", 32'(valid_b),     32'd0);
        check("stale_busy",  32'(busy_b),      32'd0);
        check("stale_acc",   32'(acc_b.size()), 32'd0);

        // Single-word pass, consumer always ready.
        ready_a = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("a_read",  32'(bus_a.read),    32'd1);
        check("a_addr",  32'(bus_a.address), 32'd0);
        check("a_busy",  32'(busy_a),        32'd1);
        tick();
        check("a_read_drop", 32'(bus_a.read), 32'd0);
        tick();
        check("a_lo_valid", 32'(valid_a),  32'd1);
        check("a_lo",       32'(sample_a), 32'h1234);
        tick();
        check("a_hi_valid", 32'(valid_a),  32'd1);
        check("a_hi",       32'(sample_a), 32'hBEEF);
        tick();
        check("a_done",       32'(done_a),  32'd1);
        check("a_done_valid", 32'(valid_a), 32'd0);
        tick();
        check("a_done_once", 32'(done_a), 32'd0);
`ifdef FLASH_READER_LOOP_EN
        check("a_loop_busy", 32'(busy_a),     32'd1);
        check("a_loop_read", 32'(bus_a.read), 32'd1);
`else
        check("a_idle_busy", 32'(busy_a), 32'd0);

        // start while busy is neither honoured nor queued.
        n0 = acc_cnt_a;
        start_a = 1'b1; tick(); start_a = 1'b0; tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (6) tick();
        check("a_busy_start_acc",  32'(acc_cnt_a - n0), 32'd1);
        check("a_busy_start_idle", 32'(busy_a),         32'd0);
`endif

        // Three-word pass with a 5-cycle stall and 3 cycles of backpressure.
        stall_b = 5; ready_b = 1'b0; d0 = done_cnt_b;
        start_b = 1'b1; tick(); start_b = 1'b0;
        check("b_read", 32'(bus_b.read),    32'd1);
        check("b_addr", 32'(bus_b.address), 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b_stall_read", 32'(bus_b.read),    32'd1);
            check("b_stall_addr", 32'(bus_b.address), 32'd4);
        end
        stall_b = 0;
        tick();
        check("b_accept_drop", 32'(bus_b.read), 32'd0);
        tick();
        check("b_lo_valid", 32'(valid_b),  32'd1);
        check("b_lo",       32'(sample_b), 32'h5004);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_hold_sample", 32'(sample_b),   32'h5004);
            check("b_hold_valid",  32'(valid_b),    32'd1);
            check("b_hold_noread", 32'(bus_b.read), 32'd0);
        end
        ready_b = 1'b1;
        tick(); tick();
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int i = 0; i < 60; i++) begin
`ifdef FLASH_READER_LOOP_EN
            if (acc_b.size() >= 4) break;
`else
            if (busy_b == 1'b0) break;
`endif
            tick();
        end
`ifdef FLASH_READER_LOOP_EN
        check("b_acc_count",  32'(acc_b.size() >= 4), 32'd1);
        check("b_loop_addr",  32'(acc_b[3]),          32'd4);
        check("b_loop_busy",  32'(busy_b),            32'd1);
`else
        repeat (3) tick();
        check("b_acc_count",  32'(acc_b.size()), 32'd3);
        check("b_end_busy",   32'(busy_b),       32'd0);
`endif
        for (int i = 0; i < 3; i++) check("b_acc_addr", 32'(acc_b[i]), 32'(exp_addr[i]));
        check("b_smp_count", 32'(smp_b.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("b_sample", 32'(smp_b[i]), 32'(exp_smp[i]));
        check("b_done_count", 32'(done_cnt_b - d0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_sample_reader.md
# flash_sample_reader

Avalon-MM read master that streams 16-bit audio samples out of the on-board flash. Sits between the `flash` Platform Designer core (it drives the `flash_mem_*` initiator side) and the downstream sample consumer in `music`. On `start` it reads 32-bit words from a word-address window one at a time and presents each word as two 16-bit samples, low half first, over a valid/ready handshake.

## Interface
- `START_ADDR`, default 23'd0: first flash word address read.
- `END_ADDR`, default 23'h1FFFFF: last flash word address read (inclusive); must satisfy END_ADDR >= START_ADDR.
- `clk_clk` input 1: system clock (CLOCK_50 domain); all logic on rising edge.
- `reset_reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a pass; ignored unless idle.
- `flash_mem_read` output 1: Avalon read request.
- `flash_mem_address` output 23: word address.
- `flash_mem_burstcount` output 7: constant 7'd1.
- `flash_mem_write` output 1: constant 0.
- `flash_mem_byteenable` output 4: constant 4'hF.
- `flash_mem_writedata` output 32: constant 0.
- `flash_mem_waitrequest` input 1: responder stall.
- `flash_mem_readdata` input 32: returned word.
- `flash_mem_readdatavalid` input 1: `readdata` qualifier.
- `sample` output 16: current sample.
- `sample_valid` output 1: `sample` is held and valid.
- `sample_ready` input 1: consumer accepts.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the pass completes.

## Operation
- States: IDLE, REQ, WAIT_DATA, OUT_LO, OUT_HI, FINISH.
- IDLE: `start`=1 -> addr <= START_ADDR, go to REQ.
- REQ: `flash_mem_read`=1, `flash_mem_address`=addr. The request is accepted on the first rising edge where `flash_mem_waitrequest`=0. On acceptance, drop `read` and go to WAIT_DATA. Address and read stay stable while stalled.
- WAIT_DATA: on `readdatavalid`=1, capture `readdata` into a 32-bit word register and go to OUT_LO. A `readdatavalid` seen in any other state is ignored.
- OUT_LO: `sample`=word[15:0], `sample_valid`=1. Handshake completes on an edge with `sample_ready`=1; then go to OUT_HI.
- OUT_HI: `sample`=word[31:16], `sample_valid`=1. On handshake:
  - if addr == END_ADDR, go to FINISH;
  - otherwise addr <= addr+1 and go to REQ.
- FINISH: `done`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is 23-bit unsigned. Increment never passes END_ADDR.
- `start` while busy is ignored and not queued.
- Reset (any state, including mid-request): state=IDLE, `flash_mem_read`=0, `flash_mem_address`=0, `sample`=0, `sample_valid`=0, `busy`=0, `done`=0, word register=0. A response still in flight after reset is dropped.

## Timing
- `start` at edge N -> `read`=1 and `busy`=1 after edge N.
- `read` is held ≥1 cycle and for as long as `waitrequest`=1.
- `readdatavalid` at edge M -> `sample_valid`=1 with the low half after edge M.
- With `sample_ready` tied high, each half occupies one cycle. The next `read` rises the cycle after the high half is accepted.
- Exactly one outstanding read at any time; there is no pipelining.
- The responder may update its signals on the falling edge. The reader samples only on the rising edge.

## Configuration
- `FLASH_READER_LOOP_EN`
  - Defined: after the high half at END_ADDR is accepted, pulse `done` for one cycle and continue directly with REQ at START_ADDR. The reader runs until reset; `start` is needed only the first time.
  - Undefined: stop in IDLE after FINISH, as described above.

## Structure
- Shared package `flash_pkg`: state enum type, `FLASH_ADDR_W`=23, `FLASH_DATA_W`=32, `SAMPLE_W`=16, and the constant burstcount and byteenable values.
- Sub-module `flash_req_ctrl`: the REQ/WAIT_DATA Avalon read handshake. It takes `go` and an address, and returns the data word with a `word_valid` pulse. The parent FSM handles sample splitting and addressing.

## Test plan
- Reset mid-REQ (`read`=1, `waitrequest`=1): `reset_reset` for 1 cycle -> all outputs 0 next cycle. A later `readdatavalid` produces no `sample_valid`.
- START_ADDR=0, END_ADDR=0, flash model word 32'hBEEF_1234, `sample_ready`=1: `start` -> samples 16'h1234 then 16'hBEEF, then `done` one cycle, then `busy`=0.
- START_ADDR=4, END_ADDR=6: addresses observed on accepted reads are exactly 4, 5, 6. Six samples, then `done` once.
- `waitrequest` held 5 cycles: `read` and `address` stay constant all 5 cycles, with exactly one accepted request.
- `sample_ready` low for 3 cycles in OUT_LO: `sample`=low half stays stable, with no new `read` until both halves are accepted.
- With `FLASH_READER_LOOP_EN`, START_ADDR=2, END_ADDR=3: address sequence is 2, 3, 2, 3 with `done` pulsed after each 3. A second `start` mid-pass has no effect.
